jtag_tap_responder: RTL

JTAG_TAP_RESPONDER -- requirements
Module: jtag_tap_responder

---
 rtl/jtag_tap_pkg.sv | 47 ++++
 rtl/jtag_tap_responder_if.sv | 12 +
 rtl/jtag_pin_sync.sv | 40 ++++
 rtl/jtag_tap_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state codes, instruction codes, IR geometry and
// the instruction-to-data-register decode used by the responder.
package jtag_tap_pkg;

  localparam int IR_W = 4;

  typedef enum logic [3:0] {
    TAP_EX2_DR = 4'h0,
    TAP_EX1_DR = 4'h1,
    TAP_SH_DR  = 4'h2,
    TAP_PAU_DR = 4'h3,
    TAP_SEL_IR = 4'h4,
    TAP_UPD_DR = 4'h5,
    TAP_CAP_DR = 4'h6,
    TAP_SEL_DR = 4'h7,
    TAP_EX2_IR = 4'h8,
    TAP_EX1_IR = 4'h9,
    TAP_SH_IR  = 4'hA,
    TAP_PAU_IR = 4'hB,
    TAP_RTI    = 4'hC,
    TAP_UPD_IR = 4'hD,
    TAP_CAP_IR = 4'hE,
    TAP_TLR    = 4'hF
  } tap_state_e;

  localparam logic [IR_W-1:0] INSTR_IDCODE = 4'h6;
  localparam logic [IR_W-1:0] INSTR_USER   = 4'h8;
  localparam logic [IR_W-1:0] INSTR_BYPASS = 4'hF;
  localparam logic [IR_W-1:0] IR_CAPTURE   = 4'b0001;

  typedef enum logic [1:0] {
    DR_IDCODE,
    DR_USER,
    DR_BYPASS
  } dr_sel_e;

  // Unknown opcodes deliberately fall through to the 1-bit bypass register.
  function automatic dr_sel_e decode_ir(input logic [IR_W-1:0] ir);
    case (ir)
      INSTR_IDCODE: return DR_IDCODE;
      INSTR_USER:   return DR_USER;
      INSTR_BYPASS: return DR_BYPASS;
      default:      return DR_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_responder_if.sv
// JTAG pin bundle: the probe side drives TCK/TMS/TDI, the target side
// drives TDO and its enable.
interface jtag_tap_responder_if;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;

  modport master (output tck, tms, tdi, input tdo, tdo_oe);
  modport slave  (input tck, tms, tdi, output tdo, tdo_oe);
endinterface

// File: rtl/jtag_pin_sync.sv
// Brings the asynchronous JTAG pins into the i_clk domain and turns TCK
// into single-cycle rise/fall strobes.
module jtag_pin_sync (
  input  logic i_clk,
  input  logic reset,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tms_o,
  output logic tdi_o,
  output logic tck_rise_o,
  output logic tck_fall_o
);

  // Bit order in the vectors: {tck, tms, tdi}.
  logic [2:0] pin_meta_q;
  logic [2:0] pin_sync_q;
  logic       tck_dly_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      pin_meta_q <= '0;
      pin_sync_q <= '0;
      tck_dly_q  <= 1'b0;
    end else begin
      pin_meta_q <= {tck_i, tms_i, tdi_i};
      pin_sync_q <= pin_meta_q;
      tck_dly_q  <= pin_sync_q[2];
    end
  end

  // TMS/TDI share the TCK latency, so they are valid when the rise strobe fires.
  assign tms_o      = pin_sync_q[1];
  assign tdi_o      = pin_sync_q[0];
  assign tck_rise_o =  pin_sync_q[2] & ~tck_dly_q;
  assign tck_fall_o = ~pin_sync_q[2] &  tck_dly_q;

endmodule

// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP responder oversampled by i_clk: IDCODE, USER and BYPASS
// data registers behind a 4-bit instruction register.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h031820DD,
  parameter int          USER_W = 8
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_tck,
  input  logic              i_tms,
  input  logic              i_tdi,
  output logic              o_tdo,
  output logic              o_tdo_oe,
  output logic [3:0]        o_state,
  output logic [IR_W-1:0]   o_ir,
  output logic [USER_W-1:0] o_user_data,
  output logic              o_user_upd
);

  localparam int DR_W = (USER_W > 32) ? USER_W : 32;

  logic tms_s, tdi_s, tck_rise, tck_fall;

  jtag_pin_sync u_pin_sync (
    .i_clk      (i_clk),
    .reset      (reset),
    .tck_i      (i_tck),
    .tms_i      (i_tms),
    .tdi_i      (i_tdi),
    .tms_o      (tms_s),
    .tdi_o      (tdi_s),
    .tck_rise_o (tck_rise),
    .tck_fall_o (tck_fall)
  );

  tap_state_e state_q, state_d;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) state_q <= TAP_TLR;
    else       state_q <= state_d;
  end

  // NOTE: every variable written in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      case (state_q)
        TAP_TLR:    state_d = tms_s ? TAP_TLR    : TAP_RTI;
        TAP_RTI:    state_d = tms_s ? TAP_SEL_DR : TAP_RTI;
        TAP_SEL_DR: state_d = tms_s ? TAP_SEL_IR : TAP_CAP_DR;
        TAP_CAP_DR: state_d = tms_s ? TAP_EX1_DR : TAP_SH_DR;
        TAP_SH_DR:  state_d = tms_s ? TAP_EX1_DR : TAP_SH_DR;
        TAP_EX1_DR: state_d = tms_s ? TAP_UPD_DR : TAP_PAU_DR;
        TAP_PAU_DR: state_d = tms_s ? TAP_EX2_DR : TAP_PAU_DR;
        TAP_EX2_DR: state_d = tms_s ? TAP_UPD_DR : TAP_SH_DR;
        TAP_UPD_DR: state_d = tms_s ? TAP_SEL_DR : TAP_RTI;
        TAP_SEL_IR: state_d = tms_s ? TAP_TLR    : TAP_CAP_IR;
        TAP_CAP_IR: state_d = tms_s ? TAP_EX1_IR : TAP_SH_IR;
        TAP_SH_IR:  state_d = tms_s ? TAP_EX1_IR : TAP_SH_IR;
        TAP_EX1_IR: state_d = tms_s ? TAP_UPD_IR : TAP_PAU_IR;
        TAP_PAU_IR: state_d = tms_s ? TAP_EX2_IR : TAP_PAU_IR;
        TAP_EX2_IR: state_d = tms_s ? TAP_UPD_IR : TAP_SH_IR;
        TAP_UPD_IR: state_d = tms_s ? TAP_SEL_DR : TAP_RTI;
        default:    state_d = TAP_TLR;
      endcase
    end
  end

  logic [IR_W-1:0]   ir_q, ir_d;
  logic [IR_W-1:0]   ir_sr_q, ir_sr_d;
  logic [DR_W-1:0]   dr_sr_q, dr_sr_d;
  logic [USER_W-1:0] user_q, user_d;
  logic              user_upd_q, user_upd_d;
  logic              tdo_q, tdo_d;
  logic              tdo_oe_q, tdo_oe_d;
  dr_sel_e           dr_sel;
  logic [DR_W-1:0]   dr_capture, dr_shift;

  assign dr_sel = decode_ir(ir_q);

  // One physical shift register serves all data registers; the selected
  // length only decides where TDI enters.
  always_comb begin
    dr_capture = '0;
    dr_shift   = dr_sr_q >> 1;
    case (dr_sel)
      DR_IDCODE: begin
        dr_capture[31:0] = IDCODE;
        dr_shift[31]     = tdi_s;
      end
      DR_USER: begin
        dr_capture[USER_W-1:0] = user_q;
        dr_shift[USER_W-1]     = tdi_s;
      end
      default: dr_shift[0] = tdi_s;
    endcase
  end

  always_comb begin
    ir_d       = ir_q;
    ir_sr_d    = ir_sr_q;
    dr_sr_d    = dr_sr_q;
    user_d     = user_q;
    user_upd_d = 1'b0;
    tdo_d      = tdo_q;
    tdo_oe_d   = tdo_oe_q;
    if (tck_rise) begin
      case (state_q)
        TAP_CAP_IR: ir_sr_d = IR_CAPTURE;
        TAP_SH_IR:  ir_sr_d = {tdi_s, ir_sr_q[IR_W-1:1]};
        TAP_UPD_IR: ir_d    = ir_sr_q;
        TAP_CAP_DR: dr_sr_d = dr_capture;
        TAP_SH_DR:  dr_sr_d = dr_shift;
        TAP_UPD_DR: begin
          if (dr_sel == DR_USER) begin
            user_d     = dr_sr_q[USER_W-1:0];
            user_upd_d = 1'b1;
          end
        end
        default: ;
      endcase
      if (state_d == TAP_TLR) ir_d = INSTR_IDCODE;
    end
    if (tck_fall) begin
      case (state_q)
        TAP_SH_IR: begin
          tdo_d    = ir_sr_q[0];
          tdo_oe_d = 1'b1;
        end
        TAP_SH_DR: begin
          tdo_d    = dr_sr_q[0];
          tdo_oe_d = 1'b1;
        end
        default: begin
          tdo_d    = 1'b1;
          tdo_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      ir_q       <= INSTR_IDCODE;
      // NOTE: the shift registers are cleared too, so a scan aborted by reset
      // cannot leak partial data into a later capture or update.
      ir_sr_q    <= '0;
      dr_sr_q    <= '0;
      user_q     <= '0;
      user_upd_q <= 1'b0;
      tdo_q      <= 1'b1;
      tdo_oe_q   <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_sr_q    <= ir_sr_d;
      dr_sr_q    <= dr_sr_d;
      user_q     <= user_d;
      user_upd_q <= user_upd_d;
      tdo_q      <= tdo_d;
      tdo_oe_q   <= tdo_oe_d;
    end
  end

  assign o_state     = state_q;
  assign o_ir        = ir_q;
  assign o_user_data = user_q;
  assign o_user_upd  = user_upd_q;
  assign o_tdo       = tdo_q;
  assign o_tdo_oe    = tdo_oe_q;

endmodule
